// File: rtl/spi_seq_pkg.sv
// Shared types and register map helpers for the SPI transaction sequencer.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, GUARD, POLL, RD_ISS, RD_CAP, DONE
  } state_t;

  localparam int unsigned OFF_WRITE = 0;
  localparam int unsigned OFF_READ  = 1;
  localparam int unsigned OFF_START = 2;
  localparam int unsigned OFF_BUSY  = 3;

  function automatic logic [31:0] addr_of(input int unsigned base,
                                          input int unsigned wording,
                                          input int unsigned k);
    return 32'(base + k * wording);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr_i.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand     = (int'(ptr_i) + k) % N;
      cand_idx = IW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Arbitrates requesters onto one spi_master and runs load/start/poll/read
// register sequences on its bus, returning the received word.
module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned BYTES_PER_TXN  = 1,
  parameter int unsigned SPI_BASE_ADDR  = 0,
  parameter int unsigned ADDR_WORDING   = 1,
  parameter int unsigned address_width  = 16,
  parameter int unsigned data_width     = 8,
  parameter int unsigned START_GUARD    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*8*BYTES_PER_TXN-1:0] req_tx_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [8*BYTES_PER_TXN-1:0]      rsp_rx_data_o,
  output logic                            rsp_err_o,
  output logic                            busy_o,
  output logic [address_width-1:0]        spi_addr_o,
  output logic [data_width-1:0]           spi_data_o,
  output logic                            spi_rd_wr_o,
  input  logic [data_width-1:0]           spi_data_i
);

  localparam int unsigned TW  = 8 * BYTES_PER_TXN;
  localparam int unsigned IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW  = (BYTES_PER_TXN > 1) ? $clog2(BYTES_PER_TXN) : 1;
  localparam int unsigned TOW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned GW  = $clog2(START_GUARD + 1);
  localparam int unsigned TMW = (TOW > GW) ? TOW : GW;

  localparam logic [address_width-1:0] A_WRITE = address_width'(addr_of(SPI_BASE_ADDR, ADDR_WORDING, OFF_WRITE));
  localparam logic [address_width-1:0] A_READ  = address_width'(addr_of(SPI_BASE_ADDR, ADDR_WORDING, OFF_READ));
  localparam logic [address_width-1:0] A_START = address_width'(addr_of(SPI_BASE_ADDR, ADDR_WORDING, OFF_START));
  localparam logic [address_width-1:0] A_BUSY  = address_width'(addr_of(SPI_BASE_ADDR, ADDR_WORDING, OFF_BUSY));

  localparam logic [CW-1:0]  LAST_BYTE  = CW'(BYTES_PER_TXN - 1);
  localparam logic [TMW-1:0] LAST_GUARD = TMW'(START_GUARD - 1);
  localparam logic [TMW-1:0] LAST_POLL  = TMW'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [TW-1:0]        tx_q, tx_d, rx_q, rx_d, rsp_rx_q, rsp_rx_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TMW-1:0]       tmr_q, tmr_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [TW-1:0]        tx_sel;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    tx_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) tx_sel = req_tx_data_i[i*TW +: TW];
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign rsp_rx_data_o = rsp_rx_q;
  assign rsp_err_o     = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_rx_d    = rsp_rx_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    spi_addr_o  = A_BUSY;
    spi_data_o  = '0;
    spi_rd_wr_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready_o = arb_gnt;
          gnt_d       = arb_gnt;
          ptr_d       = arb_idx;
          tx_d        = tx_sel;
          rx_d        = '0;
          cnt_d       = '0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        // tx word shifts left so the top byte is always the next one out
        spi_addr_o  = A_WRITE;
        spi_rd_wr_o = 1'b1;
        spi_data_o  = data_width'(tx_q[TW-1 -: 8]);
        tx_d        = tx_q << 8;
        if (cnt_q == LAST_BYTE) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        spi_addr_o  = A_START;
        spi_rd_wr_o = 1'b1;
        spi_data_o  = data_width'(1);
        tmr_d       = '0;
        state_d     = GUARD;
      end
      GUARD: begin
        if (tmr_q == LAST_GUARD) begin
          tmr_d   = '0;
          state_d = POLL;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      POLL: begin
        if (!spi_data_i[0]) begin
          cnt_d   = '0;
          state_d = RD_ISS;
        end else if (TIMEOUT_CYCLES != 0 && tmr_q == LAST_POLL) begin
          rsp_rx_d  = '0;
          rsp_err_d = 1'b1;
          state_d   = DONE;
        end else if (tmr_q != '1) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RD_ISS: begin
        spi_addr_o = A_READ;
        state_d    = RD_CAP;
      end
      RD_CAP: begin
        rx_d = TW'({rx_q, spi_data_i[7:0]});
        if (cnt_q == LAST_BYTE) begin
          rsp_rx_d  = rx_d;
          rsp_err_d = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = RD_ISS;
        end
      end
      DONE: begin
        rsp_valid_o = gnt_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NUM_REQ - 1);
      gnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rsp_rx_q  <= '0;
      rsp_err_q <= 1'b0;
      cnt_q     <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rsp_rx_q  <= rsp_rx_d;
      rsp_err_q <= rsp_err_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
    end
  end

endmodule
